game_timer_ctrl: RTL and testbench

//  Sequences the Sudoku game timer: waits for the player's first move, runs a
//  1 s time base and BCD mm:ss counter while the puzzle is unsolved, and freezes
//  on the win signal. Sits between the board input logic (buttons, write switch,

---
 rtl/sudoku_pkg.sv | 14 +
 rtl/game_timer_ctrl_bcd_digit.sv | 32 +++
 rtl/game_timer_ctrl.sv | 125 ++++++++++++
 tb/tb_game_timer_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared encodings for the Sudoku game timer: FSM states and BCD digit limits.
package sudoku_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2,
    WON  = 2'd3
  } timerState_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/game_timer_ctrl_bcd_digit.sv
// One BCD digit of the mm:ss counter. It wraps at MAX_VAL and reports a carry.
// The freeze input blocks the update when the whole chain would roll over.
module bcd_digit
  import sudoku_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = DIGIT_MAX
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       freeze,
  output logic [3:0] digit,
  output logic       carryOut
);

  logic atMax_s;

  assign atMax_s  = (digit == MAX_VAL);
  assign carryOut = en & atMax_s;

  // digit register: increment with wrap when enabled and not frozen
  always_ff @(posedge CLK) begin
    if (!RST) begin
      digit <= 4'd0;
    end else if (en && !freeze) begin
      digit <= atMax_s ? 4'd0 : (digit + 4'd1);
    end else begin
      digit <= digit;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Sudoku game timer sequencer: it waits for the first move, then counts mm:ss
// from a divided clock. It saturates at 99:59 and freezes when the board is solved.
module game_timer_ctrl
  import sudoku_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WinSig,
  input  logic       upButton,
  input  logic       downButton,
  input  logic       leftButton,
  input  logic       rightButton,
  input  logic       writeSwitch,
  output logic       gameStart,
  output logic       gameWon,
  output logic       secTick,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic [3:0] minTens
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);

  timerState_t      state_r;
  timerState_t      nextState_s;
  logic [DIV_W-1:0] prescaler_r;
  logic [3:0]       btnNow_s;
  logic [3:0]       btnPrev_r;
  logic             wsPrev_r;
  logic             activity_s;
  logic             tickDue_s;
  logic             secOnesCarry_s;
  logic             secTensCarry_s;
  logic             minOnesCarry_s;
  logic             rollover_s;

  assign btnNow_s   = {upButton, downButton, leftButton, rightButton};
  assign activity_s = (|(btnNow_s & ~btnPrev_r)) | (writeSwitch ^ wsPrev_r);
  // A solved board takes priority over a second boundary that falls on the same cycle.
  assign tickDue_s  = (state_r == RUN) && (prescaler_r == DIV_LAST) && !WinSig;

  // rollover_s is the carry out of minTens: a tick is due while showing 99:59
  bcd_digit #(.MAX_VAL(DIGIT_MAX)) uSecOnes (
    .CLK(CLK), .RST(RST), .en(tickDue_s), .freeze(rollover_s),
    .digit(secOnes), .carryOut(secOnesCarry_s)
  );
  bcd_digit #(.MAX_VAL(SEC_TENS_MAX)) uSecTens (
    .CLK(CLK), .RST(RST), .en(secOnesCarry_s), .freeze(rollover_s),
    .digit(secTens), .carryOut(secTensCarry_s)
  );
  bcd_digit #(.MAX_VAL(DIGIT_MAX)) uMinOnes (
    .CLK(CLK), .RST(RST), .en(secTensCarry_s), .freeze(rollover_s),
    .digit(minOnes), .carryOut(minOnesCarry_s)
  );
  bcd_digit #(.MAX_VAL(DIGIT_MAX)) uMinTens (
    .CLK(CLK), .RST(RST), .en(minOnesCarry_s), .freeze(rollover_s),
    .digit(minTens), .carryOut(rollover_s)
  );

  // next-state logic for the game sequence
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (WinSig) begin
          nextState_s = WON;
        end else if (activity_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (WinSig) begin
          nextState_s = WON;
        end else if (rollover_s) begin
          nextState_s = SAT;
        end else begin
          nextState_s = RUN;
        end
      end
      SAT: begin
        if (WinSig) begin
          nextState_s = WON;
        end else begin
          nextState_s = SAT;
        end
      end
      WON:     nextState_s = WON;
      default: nextState_s = IDLE;
    endcase
  end

  // state, prescaler, edge-detect history and registered status outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r     <= IDLE;
      prescaler_r <= DIV_ZERO;
      btnPrev_r   <= btnNow_s;
      wsPrev_r    <= writeSwitch;
      secTick     <= 1'b0;
      gameStart   <= 1'b0;
      gameWon     <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      btnPrev_r <= btnNow_s;
      wsPrev_r  <= writeSwitch;
      secTick   <= tickDue_s;
      gameStart <= (nextState_s == RUN) || (nextState_s == SAT);
      gameWon   <= (nextState_s == WON);
      if ((state_r == RUN) && !WinSig) begin
        prescaler_r <= (prescaler_r == DIV_LAST) ? DIV_ZERO : (prescaler_r + DIV_ONE);
      end else begin
        prescaler_r <= DIV_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: one instance with TICK_DIV=4 and one with TICK_DIV=1.
// Stimulus pushes expectations into queues, and a negedge monitor consumes and compares them.
module tb_game_timer_ctrl;

  typedef struct {
    string name;
    int    kind;     // 0: dut4 outputs, 1: dut1 outputs, 2: dut1 tick count, 3: dut4 pending ticks
    int    expVal;
  } snap_t;

  logic CLK;
  logic RST4, RST1;
  logic win4, win1;
  logic up, down, left, right, ws;

  logic       gameStart4, gameWon4, secTick4;
  logic [3:0] secOnes4, secTens4, minOnes4, minTens4;
  logic       gameStart1, gameWon1, secTick1;
  logic [3:0] secOnes1, secTens1, minOnes1, minTens1;

  logic [17:0] obs4, obs1;
  logic [15:0] time4;

  snap_t       snapQ[$];
  logic [15:0] tickQ[$];
  int          checks = 0;
  int          errors = 0;
  int          ticks1 = 0;

  game_timer_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut4 (
    .CLK(CLK), .RST(RST4), .WinSig(win4),
    .upButton(up), .downButton(down), .leftButton(left), .rightButton(right),
    .writeSwitch(ws),
    .gameStart(gameStart4), .gameWon(gameWon4), .secTick(secTick4),
    .secOnes(secOnes4), .secTens(secTens4), .minOnes(minOnes4), .minTens(minTens4)
  );

  game_timer_ctrl #(.TICK_DIV(1), .DIV_W(1)) dut1 (
    .CLK(CLK), .RST(RST1), .WinSig(win1),
    .upButton(up), .downButton(down), .leftButton(left), .rightButton(right),
    .writeSwitch(ws),
    .gameStart(gameStart1), .gameWon(gameWon1), .secTick(secTick1),
    .secOnes(secOnes1), .secTens(secTens1), .minOnes(minOnes1), .minTens(minTens1)
  );

  assign time4 = {minTens4, minOnes4, secTens4, secOnes4};
  assign obs4  = {gameStart4, gameWon4, time4};
  assign obs1  = {gameStart1, gameWon1, minTens1, minOnes1, secTens1, secOnes1};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] bcdTime(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int expOut(input bit gs, input bit gw, input int secs);
    logic [17:0] v;
    v = {gs, gw, bcdTime(secs)};
    return int'(v);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushSnap(input string name, input int kind, input int expVal);
    snap_t s;
    s.name   = name;
    s.kind   = kind;
    s.expVal = expVal;
    snapQ.push_back(s);
  endtask

  task automatic pushTicks(input int n);
    for (int k = 1; k <= n; k++) tickQ.push_back(bcdTime(k));
  endtask

  // monitor: every dut4 tick is matched to the next expected time; snapshots are checked on request
  always @(negedge CLK) begin
    snap_t       s;
    logic [15:0] et;
    int          act;
    if (secTick4) begin
      checks++;
      if (tickQ.size() == 0) begin
        errors++;
        $display("FAIL tick4_unexpected: secTick at time %h, required no tick", time4);
      end else begin
        et = tickQ.pop_front();
        if (time4 !== et) begin
          errors++;
          $display("FAIL tick4_time: actual %h required %h", time4, et);
        end
      end
    end
    if (secTick1) ticks1++;
    while (snapQ.size() > 0) begin
      s = snapQ.pop_front();
      checks++;
      case (s.kind)
        0:       act = int'(obs4);
        1:       act = int'(obs1);
        2:       act = ticks1;
        3:       act = tickQ.size();
        default: act = -1;
      endcase
      if (act != s.expVal) begin
        errors++;
        $display("FAIL %s: actual %0h required %0h", s.name, act, s.expVal);
      end
    end
  end

  initial begin
    RST4 = 1'b0; RST1 = 1'b0; win4 = 1'b0; win1 = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; ws = 1'b0;

    // reset holds everything at zero while the buttons toggle
    for (int i = 0; i < 3; i++) begin
      up = i[0]; right = ~i[0]; ws = i[1];
      step();
      pushSnap("rst_hold", 0, expOut(1'b0, 1'b0, 0));
    end
    up = 1'b0; right = 1'b0; ws = 1'b0;
    step();
    RST4 = 1'b1;
    step();
    pushSnap("idle_quiet", 0, expOut(1'b0, 1'b0, 0));

    // first move, then one full minute of ticks
    pushTicks(60);
    up = 1'b1;
    step();
    pushSnap("start_up", 0, expOut(1'b1, 1'b0, 0));
    up = 1'b0;
    repeat (239) step();
    pushSnap("before_min", 0, expOut(1'b1, 1'b0, 59));
    step();
    pushSnap("one_min", 0, expOut(1'b1, 1'b0, 60));
    pushSnap("ticks_60_done", 3, 0);

    // left button held across reset is not a move; a writeSwitch fall is
    RST4 = 1'b0; left = 1'b1; ws = 1'b1;
    step();
    pushSnap("reset_at_1min", 0, expOut(1'b0, 1'b0, 0));
    RST4 = 1'b1;
    step();
    step();
    pushSnap("held_left_idle", 0, expOut(1'b0, 1'b0, 0));
    pushTicks(42);
    ws = 1'b0;
    step();
    pushSnap("ws_fall_start", 0, expOut(1'b1, 1'b0, 0));
    repeat (168) step();
    pushSnap("at_42", 0, expOut(1'b1, 1'b0, 42));

    // one-cycle reset in the middle of a run
    RST4 = 1'b0;
    step();
    pushSnap("mid_reset", 0, expOut(1'b0, 1'b0, 0));
    pushSnap("ticks_42_done", 3, 0);
    RST4 = 1'b1;
    step();
    pushTicks(7);
    up = 1'b1;
    step();
    pushSnap("restart", 0, expOut(1'b1, 1'b0, 0));
    up = 1'b0;
    repeat (3) step();
    pushSnap("pre_first_tick", 0, expOut(1'b1, 1'b0, 0));
    step();
    pushSnap("first_tick", 0, expOut(1'b1, 1'b0, 1));
    repeat (24) step();
    pushSnap("at_7", 0, expOut(1'b1, 1'b0, 7));

    // the win arrives on the cycle a tick is due
    repeat (3) step();
    pushSnap("tick_pending", 0, expOut(1'b1, 1'b0, 7));
    win4 = 1'b1;
    step();
    pushSnap("win_on_tick", 0, expOut(1'b0, 1'b1, 7));
    win4 = 1'b0; up = 1'b1;
    step();
    up = 1'b0; down = 1'b1;
    step();
    down = 1'b0; ws = 1'b1;
    step();
    ws = 1'b0;
    step();
    pushSnap("won_hold", 0, expOut(1'b0, 1'b1, 7));
    pushSnap("ticks_7_done", 3, 0);

    // TICK_DIV=1 instance runs to saturation
    RST1 = 1'b1;
    step();
    down = 1'b1;
    step();
    pushSnap("start1", 1, expOut(1'b1, 1'b0, 0));
    down = 1'b0;
    repeat (5999) step();
    pushSnap("full_9959", 1, expOut(1'b1, 1'b0, 5999));
    pushSnap("ticks_5999", 2, 5999);
    step();
    pushSnap("sat_tick", 1, expOut(1'b1, 1'b0, 5999));
    pushSnap("ticks_6000", 2, 6000);
    up = 1'b1;
    repeat (5) step();
    up = 1'b0;
    pushSnap("sat_hold", 1, expOut(1'b1, 1'b0, 5999));
    pushSnap("ticks_held", 2, 6000);
    win1 = 1'b1;
    step();
    pushSnap("sat_to_won", 1, expOut(1'b0, 1'b1, 5999));

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
